// File: rtl/instr_encoder_if.sv
// Handshake bundle for the RV32I instruction encoder: field/immediate input
// beat, address-load control and the encoded-word output beat.
interface instr_encoder_if;
   logic               in_valid;
   logic               in_ready;
   logic        [2:0]  fmt;
   logic        [6:0]  opcode;
   logic        [4:0]  rd;
   logic        [4:0]  rs1;
   logic        [4:0]  rs2;
   logic        [2:0]  funct3;
   logic        [6:0]  funct7;
   logic signed [31:0] imm;
   logic               addr_load;
   logic        [31:0] addr_in;
   logic               out_valid;
   logic               out_ready;
   logic        [31:0] instr;
   logic        [31:0] out_addr;
   logic               err;
   logic        [7:0]  err_cnt;

   // Producer/consumer side (loader, sequencer, testbench)
   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             addr_load, addr_in, out_ready,
      input  in_ready, out_valid, instr, out_addr, err, err_cnt
   );

   // Encoder side
   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             addr_load, addr_in, out_ready,
      output in_ready, out_valid, instr, out_addr, err, err_cnt
   );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder. S1 captures the decoded fields, S2
// holds the packed instruction word (or a NOP when the immediate does not fit
// the chosen format) together with a running word address and error count.
module instr_encoder (
   input  logic            clk,
   input  logic            rst,
   instr_encoder_if.slave  bus
);

   localparam logic [2:0]  FMT_I = 3'd0;
   localparam logic [2:0]  FMT_S = 3'd1;
   localparam logic [2:0]  FMT_B = 3'd2;
   localparam logic [2:0]  FMT_U = 3'd3;
   localparam logic [2:0]  FMT_J = 3'd4;
   localparam logic [2:0]  FMT_R = 3'd5;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   // Immediate representability check; illegal formats always fail.
   function automatic logic f_range_err(input logic [2:0] fmt,
                                        input logic signed [31:0] imm);
      logic e;
      case (fmt)
         FMT_I, FMT_S: e = (imm < -32'sd2048) || (imm > 32'sd2047);
         FMT_B:        e = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
         FMT_J:        e = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
         FMT_U:        e = (imm[11:0] != 12'd0);
         FMT_R:        e = 1'b0;
         default:      e = 1'b1;
      endcase
      return e;
   endfunction

   // Scatter the immediate and register fields into the RV32I bit layout.
   function automatic logic [31:0] f_pack(input logic [2:0]         fmt,
                                          input logic [6:0]         op,
                                          input logic [4:0]         rd,
                                          input logic [4:0]         rs1,
                                          input logic [4:0]         rs2,
                                          input logic [2:0]         f3,
                                          input logic [6:0]         f7,
                                          input logic signed [31:0] imm);
      logic [31:0] w;
      case (fmt)
         FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
         FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         FMT_U:   w = {imm[31:12], rd, op};
         FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
         default: w = NOP;
      endcase
      return w;
   endfunction

   // S1 registers
   logic               r_vld_p1;
   logic        [2:0]  r_fmt_p1;
   logic        [6:0]  r_opcode_p1;
   logic        [4:0]  r_rd_p1;
   logic        [4:0]  r_rs1_p1;
   logic        [4:0]  r_rs2_p1;
   logic        [2:0]  r_funct3_p1;
   logic        [6:0]  r_funct7_p1;
   logic signed [31:0] r_imm_p1;

   // S2 / output registers
   logic               r_vld_p2;
   logic        [31:0] r_instr_p2;
   logic               r_err_p2;
   logic        [31:0] r_addr;
   logic        [7:0]  r_err_cnt;

   logic               w_s2_load;
   logic               w_in_ready;
   logic               w_in_hs;
   logic               w_out_hs;
   logic               w_enc_err;
   logic        [31:0] w_enc_instr;

   assign w_s2_load  = !r_vld_p2 || bus.out_ready;
   assign w_in_ready = !r_vld_p1 || w_s2_load;
   assign w_in_hs    = bus.in_valid && w_in_ready;
   assign w_out_hs   = r_vld_p2 && bus.out_ready;

   // ---- S1: capture accepted fields ----
   // S1 valid flag: refills or empties whenever the stage is allowed to move.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_p1 <= 1'b0;
      end else if (w_in_ready) begin
         r_vld_p1 <= bus.in_valid;
      end
   end

   // S1 datapath: field capture on an input handshake, no reset needed.
   always_ff @(posedge clk) begin
      if (w_in_hs) begin
         r_fmt_p1    <= bus.fmt;
         r_opcode_p1 <= bus.opcode;
         r_rd_p1     <= bus.rd;
         r_rs1_p1    <= bus.rs1;
         r_rs2_p1    <= bus.rs2;
         r_funct3_p1 <= bus.funct3;
         r_funct7_p1 <= bus.funct7;
         r_imm_p1    <= bus.imm;
      end
   end

   // ---- S1 -> S2: combinational encode ----
   // Out-of-range immediates and illegal formats collapse to a NOP.
   always_comb begin
      w_enc_err   = f_range_err(r_fmt_p1, r_imm_p1);
      w_enc_instr = NOP;
      if (!w_enc_err) begin
         w_enc_instr = f_pack(r_fmt_p1, r_opcode_p1, r_rd_p1, r_rs1_p1,
                              r_rs2_p1, r_funct3_p1, r_funct7_p1, r_imm_p1);
      end
   end

   // ---- S2: output register ----
   // Output beat: load from S1 when empty or drained, otherwise hold stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_p2   <= 1'b0;
         r_instr_p2 <= 32'd0;
         r_err_p2   <= 1'b0;
      end else if (w_s2_load) begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_instr_p2 <= w_enc_instr;
            r_err_p2   <= w_enc_err;
         end
      end
   end

   // Word address: a load wins over the post-handshake increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= 32'd0;
      end else if (bus.addr_load) begin
         r_addr <= bus.addr_in;
      end else if (w_out_hs) begin
         r_addr <= r_addr + 32'd4;
      end
   end

   // Saturating count of error beats actually delivered to the consumer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt <= 8'd0;
      end else if (w_out_hs && r_err_p2 && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_vld_p2;
   assign bus.instr     = r_instr_p2;
   assign bus.err       = r_err_p2;
   assign bus.out_addr  = r_addr;
   assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected words when a
// beat is accepted, the monitor pops and compares on each output handshake.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst = 1'b0;

   instr_encoder_if bus();

   instr_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   exp_t        q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          bp_mode = 0;      // 0: ready, 1: random, 2: stalled
   bit          ld_req = 1'b0;
   logic [31:0] ld_val = 32'd0;
   logic [31:0] m_addr = 32'd0;
   int          m_cnt  = 0;
   bit          prev_stall = 1'b0;
   bit          pv_ld = 1'b0;
   logic [31:0] pv_instr = 32'd0;
   logic [31:0] pv_addr  = 32'd0;
   logic        pv_err   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] fld(input logic [31:0] u, input int hi, input int lo);
      return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   // Reference encoder built from the format rules with plain arithmetic.
   function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                  input logic [4:0] rd_, input logic [4:0] rs1_,
                                  input logic [4:0] rs2_, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] u);
      exp_t   r;
      longint v;
      logic [31:0] base;
      v    = longint'($signed(u));
      base = 32'(op) + (32'(f3) << 12) + (32'(rs1_) << 15);
      r.err   = 1'b0;
      r.instr = 32'h13;
      case (f)
         3'd0: begin
            r.err   = (v < -2048) || (v > 2047);
            r.instr = base + (32'(rd_) << 7) + (fld(u, 11, 0) << 20);
         end
         3'd1: begin
            r.err   = (v < -2048) || (v > 2047);
            r.instr = base + (32'(rs2_) << 20) + (fld(u, 4, 0) << 7) + (fld(u, 11, 5) << 25);
         end
         3'd2: begin
            r.err   = (v < -4096) || (v > 4094) || (v % 2 != 0);
            r.instr = base + (32'(rs2_) << 20) + (fld(u, 12, 12) << 31) + (fld(u, 10, 5) << 25)
                      + (fld(u, 4, 1) << 8) + (fld(u, 11, 11) << 7);
         end
         3'd3: begin
            r.err   = (u % 4096) != 0;
            r.instr = (u / 4096) * 4096 + (32'(rd_) << 7) + 32'(op);
         end
         3'd4: begin
            r.err   = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
            r.instr = 32'(op) + (32'(rd_) << 7) + (fld(u, 20, 20) << 31) + (fld(u, 10, 1) << 21)
                      + (fld(u, 11, 11) << 20) + (fld(u, 19, 12) << 12);
         end
         3'd5: r.instr = base + (32'(rd_) << 7) + (32'(rs2_) << 20) + (32'(f7) << 25);
         default: r.err = 1'b1;
      endcase
      if (r.err) r.instr = 32'h13;
      return r;
   endfunction

   // Called just after a rising edge; returns just after the edge that took the beat.
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_,
                       input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im,
                       input bit use_lit, input logic [31:0] lit_i, input logic lit_e);
      exp_t e;
      int   waited = 0;
      if (use_lit) begin
         e.instr = lit_i;
         e.err   = lit_e;
      end else begin
         e = model(f, op, rd_, rs1_, rs2_, f3, f7, im);
      end
      bus.fmt = f; bus.opcode = op; bus.rd = rd_; bus.rs1 = rs1_; bus.rs2 = rs2_;
      bus.funct3 = f3; bus.funct7 = f7; bus.imm = im;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            q.push_back(e);
            @(posedge clk); #1;
            break;
         end
         waited++;
         if (waited > 200) begin
            n_chk++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", waited);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Consumer side: out_ready pattern and address-load pulses.
   initial begin
      bus.out_ready = 1'b1;
      bus.addr_load = 1'b0;
      bus.addr_in   = 32'd0;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
         endcase
         if (ld_req) begin
            bus.addr_load = 1'b1;
            bus.addr_in   = ld_val;
            ld_req        = 1'b0;
         end else if (bp_mode == 1 && $urandom_range(0, 19) == 0) begin
            bus.addr_load = 1'b1;
            bus.addr_in   = $urandom;
         end else begin
            bus.addr_load = 1'b0;
         end
      end
   end

   // Monitor: mid-cycle sampling of the output beat and stall stability.
   always @(negedge clk) begin : mon
      logic hs;
      exp_t e;
      if (rst) begin
         hs = bus.out_valid && bus.out_ready;
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_instr", bus.instr, pv_instr);
            chk("stall_err", 32'(bus.err), 32'(pv_err));
            if (!pv_ld) chk("stall_addr", bus.out_addr, pv_addr);
         end
         if (hs) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_beat: got instr 0x%08h, expected no beat", bus.instr);
            end else begin
               e = q.pop_front();
               chk("instr", bus.instr, e.instr);
               chk("err", 32'(bus.err), 32'(e.err));
               chk("out_addr", bus.out_addr, m_addr);
               chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
               if (e.err && m_cnt < 255) m_cnt++;
            end
         end
         if (bus.addr_load) m_addr = bus.addr_in;
         else if (hs)       m_addr = m_addr + 32'd4;
         prev_stall = bus.out_valid && !bus.out_ready;
         pv_ld      = bus.addr_load;
         pv_instr   = bus.instr;
         pv_addr    = bus.out_addr;
         pv_err     = bus.err;
      end
   end

   int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                   -1048577, -1048576, 1048574, 1048575, 1048576};

   initial begin : main
      logic [31:0] im;
      bus.in_valid = 1'b0;
      bus.fmt = 3'd0; bus.opcode = 7'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
      bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'sd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_out_addr", bus.out_addr, 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      rst = 1'b1;
      idle(1);

      // First beat, then a second to see the address advance
      send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093, 1'b0);
      send(3'd0, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 0, 32'd0, 1'b0);
      idle(4);

      // Back-to-back S, B, J, U
      send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 32'h0020A423, 1'b0);
      send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1, 32'hFE208EE3, 1'b0);
      send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1, 32'h001000EF, 1'b0);
      send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7, 1'b0);
      idle(4);

      // Error beats
      send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h13, 1'b1);
      idle(4);
      chk("err_cnt_first", 32'(bus.err_cnt), 32'd1);
      send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1, 32'h13, 1'b1);
      send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h13, 1'b1);
      idle(4);
      chk("err_cnt_three", 32'(bus.err_cnt), 32'd3);

      // Backpressure: two accepts fill the pipe, then in_ready drops
      bp_mode = 2;
      idle(1);
      send(3'd0, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11, 0, 32'd0, 1'b0);
      send(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd12, 0, 32'd0, 1'b0);
      fork
         send(3'd0, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd13, 0, 32'd0, 1'b0);
         begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            repeat (5) @(posedge clk);
            bp_mode = 0;
         end
      join
      idle(5);

      // Address load and wrap
      ld_val = 32'hFFFF_FFFC;
      ld_req = 1'b1;
      idle(2);
      send(3'd5, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 0, 32'd0, 1'b0);
      send(3'd5, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h00, 32'd0, 0, 32'd0, 1'b0);
      idle(4);
      chk("addr_wrapped", bus.out_addr, 32'd4);
      send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 0, 32'd0, 1'b0);
      send(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2, 0, 32'd0, 1'b0);
      ld_val = 32'h100;
      ld_req = 1'b1;
      send(3'd0, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd3, 0, 32'd0, 1'b0);
      idle(5);

      // Randomised traffic with random backpressure and address loads
      bp_mode = 1;
      repeat (300) begin
         case ($urandom_range(0, 3))
            0:       im = 32'(int'($urandom_range(0, 8191)) - 4096);
            1:       im = $urandom;
            2:       im = 32'(bnd[$urandom_range(0, 13)]);
            default: im = $urandom & 32'hFFFF_F000;
         endcase
         send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), 7'($urandom), im, 0, 32'd0, 1'b0);
      end
      bp_mode = 0;
      idle(10);

      // Saturation of the error counter
      repeat (300) send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 0, 32'd0, 1'b0);
      idle(5);
      chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
      chk("queue_drained", 32'(q.size()), 32'd0);

      // Asynchronous reset with both stages full
      bp_mode = 2;
      idle(1);
      send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd21, 0, 32'd0, 1'b0);
      send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd22, 0, 32'd0, 1'b0);
      chk("full_out_valid", 32'(bus.out_valid), 32'd1);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_out_addr", bus.out_addr, 32'd0);
      chk("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
      q.delete();
      m_addr = 32'd0;
      m_cnt = 0;
      prev_stall = 1'b0;
      bp_mode = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      idle(1);
      send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093, 1'b0);
      idle(4);
      chk("final_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
